// File: rtl/mha_pkg.sv
// ---------------------------------------------------------------------------
// mha_pkg
// Shared types and constants for the systolic-array drain path.
//   DATA_W     : word width of one array output (Q2.13)
//   FRAC_W     : fractional bits of the Q2.13 format
//   q2_13_t    : one data word
//   drain_st_e : job-tracking FSM states of sa_drain
// ---------------------------------------------------------------------------
package mha_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 13;

  typedef logic [DATA_W-1:0] q2_13_t;

  typedef enum logic {
    IDLE,
    RUN
  } drain_st_e;

endpackage

// File: rtl/sa_drain_if.sv
// ---------------------------------------------------------------------------
// sa_drain_if
// Bus bundle of sa_drain: the skewed column inputs from the array bottom edge,
// the almost-full back-pressure to the array feeder, and the row valid/ready
// port towards writeback.
//   I_OUT_VLD / I_OUT : per-column valid and data (column j at [16j+15:16j])
//   O_AFULL           : registered "some column is nearly full"
//   O_ROW_VLD / I_ROW_RDY / O_ROW / O_ROW_IDX : de-skewed row handshake
// Modports: master = producer/consumer side (bench, SA + writeback),
//           slave  = sa_drain.
// ---------------------------------------------------------------------------
interface sa_drain_if #(
  parameter int S = 64
);
  import mha_pkg::*;

  logic [S-1:0]        I_OUT_VLD;
  logic [S*DATA_W-1:0] I_OUT;
  logic                O_AFULL;
  logic                O_ROW_VLD;
  logic                I_ROW_RDY;
  logic [S*DATA_W-1:0] O_ROW;
  logic [15:0]         O_ROW_IDX;

  modport master (
    output I_OUT_VLD, I_OUT, I_ROW_RDY,
    input  O_AFULL, O_ROW_VLD, O_ROW, O_ROW_IDX
  );

  modport slave (
    input  I_OUT_VLD, I_OUT, I_ROW_RDY,
    output O_AFULL, O_ROW_VLD, O_ROW, O_ROW_IDX
  );

endinterface

// File: rtl/sa_col_fifo.sv
// ---------------------------------------------------------------------------
// sa_col_fifo
// Per-column de-skew FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, din  : write request and data; dropped when full unless popping
//   pop, dout  : read request; dout shows the head word combinationally
//   empty/full : status
//   count      : occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module sa_col_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH),
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    do_push = push && (!full || do_pop);

    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only words behind valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Head word is read combinationally so a row can launch in the cycle after
  // its last column arrives.
  assign dout  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/sa_drain.sv
// ---------------------------------------------------------------------------
// sa_drain
// Drains the systolic array's bottom edge: de-skews column outputs in one FIFO
// per column, launches whole rows onto a valid/ready port, counts rows of a
// job and reports DONE / BUSY / overflow.
// Ports:
//   I_CLK, I_RST_N : clock, asynchronous active-low reset
//   I_START        : pulse, begin job (ignored while RUN), latches I_NUM_ROWS
//   I_NUM_ROWS     : rows in the job; 0 completes immediately
//   O_DONE         : one-cycle pulse after the job's last row is accepted
//   O_BUSY         : FSM in RUN
//   O_OVF          : sticky, a column write was dropped on a full FIFO
//   bus            : sa_drain_if.slave (column inputs, AFULL, row handshake)
// Build option: SA_DRAIN_RELU_EN -- when defined, negative words are zeroed
// as they are loaded into the row register (same latency either way).
// ---------------------------------------------------------------------------
module sa_drain
  import mha_pkg::*;
#(
  parameter int S     = 64,
  parameter int DEPTH = 128,
  parameter int AF_TH = DEPTH - S
) (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic        I_START,
  input  logic [15:0] I_NUM_ROWS,
  output logic        O_DONE,
  output logic        O_BUSY,
  output logic        O_OVF,
  sa_drain_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] AF_TH_C = CW'(AF_TH);

  q2_13_t              col_dout  [S];
  logic   [CW-1:0]     col_count [S];
  logic   [S-1:0]      col_empty;
  logic   [S-1:0]      col_full;
  logic   [S-1:0]      col_drop;
  logic   [S-1:0]      col_af;
  logic   [S*DATA_W-1:0] row_load;

  drain_st_e             st_q, st_d;
  logic [15:0]           num_rows_q, num_rows_d;
  logic [15:0]           idx_q, idx_d;
  logic                  row_vld_q, row_vld_d;
  logic [S*DATA_W-1:0]   row_q, row_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  afull_q, afull_d;

  logic launch;
  logic accept;
  logic start_acc;

  // Rows leave all columns at once, so a single launch strobe pops every FIFO.
  assign accept = row_vld_q && bus.I_ROW_RDY;
  assign launch = (&(~col_empty)) && (!row_vld_q || bus.I_ROW_RDY);

  genvar gi;
  generate
    for (gi = 0; gi < S; gi++) begin : g_col
      sa_col_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk   (I_CLK),
        .rst_n (I_RST_N),
        .push  (bus.I_OUT_VLD[gi]),
        .pop   (launch),
        .din   (bus.I_OUT[gi*DATA_W +: DATA_W]),
        .dout  (col_dout[gi]),
        .empty (col_empty[gi]),
        .full  (col_full[gi]),
        .count (col_count[gi])
      );

      // A full FIFO is never empty, so launch really frees a slot here.
      assign col_drop[gi] = bus.I_OUT_VLD[gi] && col_full[gi] && !launch;
      assign col_af[gi]   = (col_count[gi] >= AF_TH_C);

`ifdef SA_DRAIN_RELU_EN
      assign row_load[gi*DATA_W +: DATA_W] =
        col_dout[gi][DATA_W-1] ? '0 : col_dout[gi];
`else
      assign row_load[gi*DATA_W +: DATA_W] = col_dout[gi];
`endif
    end
  endgenerate

  always_comb begin
    st_d       = st_q;
    num_rows_d = num_rows_q;
    idx_d      = idx_q;
    row_vld_d  = row_vld_q;
    row_d      = row_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    afull_d    = |col_af;
    start_acc  = 1'b0;

    unique case (st_q)
      IDLE: begin
        if (I_START) begin
          start_acc  = 1'b1;
          num_rows_d = I_NUM_ROWS;
          if (I_NUM_ROWS == 16'd0) begin
            done_d = 1'b1;
          end else begin
            st_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept && (idx_q == num_rows_q - 16'd1)) begin
          st_d   = IDLE;
          done_d = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase

    if (launch) begin
      row_vld_d = 1'b1;
      row_d     = row_load;
    end else if (accept) begin
      row_vld_d = 1'b0;
    end

    // Index counts every acceptance (including rows drained while IDLE);
    // a new job restarts it at 0.
    if (start_acc) begin
      idx_d = 16'd0;
    end else if (accept) begin
      idx_d = idx_q + 16'd1;
    end

    if (start_acc) begin
      ovf_d = 1'b0;
    end
    if (|col_drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      st_q       <= IDLE;
      num_rows_q <= '0;
      idx_q      <= '0;
      row_vld_q  <= 1'b0;
      row_q      <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      afull_q    <= 1'b0;
    end else begin
      st_q       <= st_d;
      num_rows_q <= num_rows_d;
      idx_q      <= idx_d;
      row_vld_q  <= row_vld_d;
      row_q      <= row_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      afull_q    <= afull_d;
    end
  end

  assign bus.O_ROW_VLD = row_vld_q;
  assign bus.O_ROW     = row_q;
  assign bus.O_ROW_IDX = idx_q;
  assign bus.O_AFULL   = afull_q;
  assign O_DONE        = done_q;
  assign O_BUSY        = (st_q == RUN);
  assign O_OVF         = ovf_q;

endmodule
